// File: rtl/spi_serf.sv
// spi_serf: SPI responder (serf) for the 16-bit SPI link.
// Receives a WIDTH-bit word on MOSI and returns tx_data on MISO, both MSB first.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   SS_n, SCLK      select and serial clock from the initiator (asynchronous)
//   MOSI, MISO      serial data in / out
//   tx_data         word returned, captured when SS_n falls
//   rx_data, rdy    last correctly framed word and its valid flag
//   clr_rdy         clears rdy and ovr
//   frm_err         one-clk pulse on a frame with the wrong bit count
//   ovr             sticky: frame completed while rdy was still set
//   busy            frame in progress
module spi_serf #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    input  logic             clr_rdy,
    output logic             frm_err,
    output logic             ovr,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ARMED, XFER} state_t;

    state_t          state, state_nxt;
    logic            ss1, ss2, ss3;
    logic            sclk1, sclk2, sclk3;
    logic            mosi1, mosi2;
    logic [WIDTH-1:0] shft_reg;
    logic            mosi_smpl;
    logic [CW-1:0]   bit_cnt;
    logic            ld, smpl, shift, done, err;

    // Synchronizers; MOSI is one stage shorter so it lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ss1, ss2, ss3}       <= 3'b111;
            {sclk1, sclk2, sclk3} <= 3'b111;
            {mosi1, mosi2}        <= 2'b11;
        end else begin
            {ss1, ss2, ss3}       <= {SS_n, ss1, ss2};
            {sclk1, sclk2, sclk3} <= {SCLK, sclk1, sclk2};
            {mosi1, mosi2}        <= {MOSI, mosi1};
        end
    end

    wire ss_fall   = ~ss2 & ss3;
    wire ss_rise   = ss2 & ~ss3;
    wire sclk_rise = sclk2 & ~sclk3;
    wire sclk_fall = ~sclk2 & sclk3;

    assign MISO = ss2 ? 1'b1 : shft_reg[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath strobes
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        smpl      = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    ld        = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                // The initiator's leading SCLK fall carries no shift.
                if (ss_rise) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    smpl      = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (ss_rise) begin
                    if (bit_cnt == CW'(WIDTH)) done = 1'b1;
                    else                       err  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    smpl  = sclk_rise;
                    shift = sclk_fall;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift path and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_reg  <= '1;
            mosi_smpl <= 1'b1;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            ovr       <= 1'b0;
            frm_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frm_err <= err;
            busy    <= (state_nxt != IDLE);
            if (smpl) mosi_smpl <= mosi2;
            if (ld) begin
                shft_reg <= tx_data;
                bit_cnt  <= '0;
            end else if (shift) begin
                shft_reg <= {shft_reg[WIDTH-2:0], mosi_smpl};
                if (bit_cnt != CW'(WIDTH)) bit_cnt <= bit_cnt + CW'(1);
            end
            // A frame end beats clr_rdy for rdy; clr_rdy still suppresses ovr.
            if (done) begin
                rx_data <= shft_reg;
                rdy     <= 1'b1;
                ovr     <= clr_rdy ? 1'b0 : (ovr | rdy);
            end else if (clr_rdy) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end
        end
    end

endmodule
